fp_ctrl: RTL and testbench

FP_CTRL -- requirements
Module: fp_ctrl

---
 rtl/fp_cons.sv | 86 ++++++++
 rtl/fp_csr.sv | 64 ++++++
 rtl/fp_ctrl.sv | 147 ++++++++++++++
 tb/tb_fp_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_cons.sv
// Shared constants for the FP controller: op classes, FSM states, CSR addresses
// and the RISC-V opcode/funct5 decode used to steer requests.
package fp_cons;

   typedef enum logic [1:0] {
      CLS_FAST    = 2'd0,
      CLS_FMA     = 2'd1,
      CLS_DIV     = 2'd2,
      CLS_ILLEGAL = 2'd3
   } op_class_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam logic [11:0] CSR_FFLAGS = 12'h001;
   localparam logic [11:0] CSR_FRM    = 12'h002;
   localparam logic [11:0] CSR_FCSR   = 12'h003;

   localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
   localparam logic [6:0] OPC_FMADD  = 7'b1000011;
   localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
   localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
   localparam logic [6:0] OPC_FNMADD = 7'b1001111;

   localparam logic [4:0] F5_FADD     = 5'b00000;
   localparam logic [4:0] F5_FSUB     = 5'b00001;
   localparam logic [4:0] F5_FMUL     = 5'b00010;
   localparam logic [4:0] F5_FDIV     = 5'b00011;
   localparam logic [4:0] F5_FSQRT    = 5'b01011;
   localparam logic [4:0] F5_FSGNJ    = 5'b00100;
   localparam logic [4:0] F5_FMINMAX  = 5'b00101;
   localparam logic [4:0] F5_FCVT_F2F = 5'b01000;
   localparam logic [4:0] F5_FCMP     = 5'b10100;
   localparam logic [4:0] F5_FCVT_F2I = 5'b11000;
   localparam logic [4:0] F5_FCVT_I2F = 5'b11010;
   localparam logic [4:0] F5_FCLASS   = 5'b11100;
   localparam logic [4:0] F5_FMV_I2F  = 5'b11110;

   typedef struct packed {
      op_class_e cls;
      logic      rm_checked;
   } op_decode_t;

   // rm_checked marks ops whose funct3 is a real rounding mode rather than a sub-opcode.
   function automatic op_decode_t decode_op(input logic [6:0] opcode,
                                            input logic [4:0] funct5,
                                            input logic       div_en);
      op_decode_t d;
      d.cls        = CLS_ILLEGAL;
      d.rm_checked = 1'b0;
      case (opcode)
         OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
            d.cls        = CLS_FMA;
            d.rm_checked = 1'b1;
         end
         OPC_OP_FP: begin
            case (funct5)
               F5_FADD, F5_FSUB, F5_FMUL: begin
                  d.cls        = CLS_FMA;
                  d.rm_checked = 1'b1;
               end
               F5_FDIV, F5_FSQRT: begin
                  if (div_en) begin
                     d.cls        = CLS_DIV;
                     d.rm_checked = 1'b1;
                  end
               end
               F5_FSGNJ, F5_FMINMAX, F5_FCMP, F5_FCLASS, F5_FMV_I2F: begin
                  d.cls = CLS_FAST;
               end
               F5_FCVT_F2I, F5_FCVT_I2F, F5_FCVT_F2F: begin
                  d.cls        = CLS_FAST;
                  d.rm_checked = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/fp_csr.sv
// fflags/frm storage and CSR decode; a write and a completion on the same edge
// apply the written value first, then OR in the completion flags.
module fp_csr
   import fp_cons::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        csr_we,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   input  logic        set_flags,
   input  logic [4:0]  flags_in,
   output logic [31:0] csr_rdata,
   output logic [2:0]  frm
);

   logic [4:0]  fflags_q, fflags_d;
   logic [2:0]  frm_q, frm_d;
   logic [23:0] wdata_unused;

   assign wdata_unused = csr_wdata[31:8];
   assign frm          = frm_q;

   always_comb begin
      fflags_d = fflags_q;
      frm_d    = frm_q;
      if (csr_we) begin
         case (csr_addr)
            CSR_FFLAGS: fflags_d = csr_wdata[4:0];
            CSR_FRM:    frm_d    = csr_wdata[2:0];
            CSR_FCSR: begin
               frm_d    = csr_wdata[7:5];
               fflags_d = csr_wdata[4:0];
            end
            default: ;
         endcase
      end
      if (set_flags) begin
         fflags_d = fflags_d | flags_in;
      end
   end

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         CSR_FFLAGS: csr_rdata = {27'd0, fflags_q};
         CSR_FRM:    csr_rdata = {29'd0, frm_q};
         CSR_FCSR:   csr_rdata = {24'd0, frm_q, fflags_q};
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         fflags_q <= '0;
         frm_q    <= '0;
      end else begin
         fflags_q <= fflags_d;
         frm_q    <= frm_d;
      end
   end

endmodule

// File: rtl/fp_ctrl.sv
// FP operation controller: classifies requests, launches FAST/FMA/DIV units and
// returns a flagged response. Define FP_CTRL_DIVSQRT_EN to enable fdiv/fsqrt.
module fp_ctrl
   import fp_cons::*;
#(
   parameter int unsigned FMA_LAT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [6:0]  req_opcode,
   input  logic [4:0]  req_funct5,
   input  logic [2:0]  req_rm,
   output logic        exe_start,
   output logic [1:0]  exe_unit,
   output logic [2:0]  exe_rm,
   input  logic        div_done,
   input  logic [4:0]  exe_flags,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_err,
   output logic [4:0]  resp_flags,
   input  logic        csr_we,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   output logic [31:0] csr_rdata,
   output logic        busy
);

   logic div_fire;

`ifdef FP_CTRL_DIVSQRT_EN
   localparam logic DIVSQRT_EN = 1'b1;
   assign div_fire = div_done;
`else
   localparam logic DIVSQRT_EN = 1'b0;
   logic div_done_unused;
   assign div_fire        = 1'b0;
   assign div_done_unused = div_done;
`endif

   state_e     state_q, state_d;
   op_class_e  unit_q, unit_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] rm_q, rm_d;
   logic       err_q, err_d;
   logic [4:0] flags_q, flags_d;
   logic [2:0] frm;
   logic [2:0] rm_res;
   logic       complete;
   op_decode_t dec;

   fp_csr u_csr (
      .clock     (clock),
      .reset     (reset),
      .csr_we    (csr_we),
      .csr_addr  (csr_addr),
      .csr_wdata (csr_wdata),
      .set_flags (complete),
      .flags_in  (exe_flags),
      .csr_rdata (csr_rdata),
      .frm       (frm)
   );

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      unit_d   = unit_q;
      cnt_d    = cnt_q;
      rm_d     = rm_q;
      err_d    = err_q;
      flags_d  = flags_q;
      complete = 1'b0;
      dec      = decode_op(req_opcode, req_funct5, DIVSQRT_EN);
      rm_res   = (req_rm == 3'b111) ? frm : req_rm;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (dec.cls == CLS_ILLEGAL ||
                   (dec.rm_checked && rm_res inside {3'b101, 3'b110, 3'b111})) begin
                  state_d = ST_RESP;
                  err_d   = 1'b1;
                  flags_d = '0;
               end else begin
                  // rm is frozen here so later frm writes leave the op in flight alone.
                  state_d = ST_EXEC;
                  unit_d  = dec.cls;
                  rm_d    = rm_res;
                  cnt_d   = '0;
                  err_d   = 1'b0;
               end
            end
         end
         ST_EXEC: begin
            case (unit_q)
               CLS_FAST: complete = 1'b1;
               CLS_FMA:  complete = (cnt_q == 4'(FMA_LAT - 1));
               CLS_DIV:  complete = div_fire;
               default:  complete = 1'b0;
            endcase
            if (complete) begin
               state_d = ST_RESP;
               flags_d = exe_flags;
            end else if (cnt_q != 4'hF) begin
               // Saturating so a long divide never re-raises exe_start.
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         unit_q  <= CLS_FAST;
         cnt_q   <= '0;
         rm_q    <= '0;
         err_q   <= 1'b0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         unit_q  <= unit_d;
         cnt_q   <= cnt_d;
         rm_q    <= rm_d;
         err_q   <= err_d;
         flags_q <= flags_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign exe_start  = (state_q == ST_EXEC) && (cnt_q == 4'd0);
   assign exe_unit   = unit_q;
   assign exe_rm     = rm_q;
   assign resp_valid = (state_q == ST_RESP);
   assign resp_err   = err_q;
   assign resp_flags = flags_q;

endmodule

// File: tb/tb_fp_ctrl.sv
// Self-checking bench for fp_ctrl: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fp_ctrl;

   localparam int LAT = 4;
`ifdef FP_CTRL_DIVSQRT_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [6:0]  req_opcode = '0;
   logic [4:0]  req_funct5 = '0;
   logic [2:0]  req_rm = '0;
   logic        exe_start;
   logic [1:0]  exe_unit;
   logic [2:0]  exe_rm;
   logic        div_done = 1'b0;
   logic [4:0]  exe_flags = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic        resp_err;
   logic [4:0]  resp_flags;
   logic        csr_we = 1'b0;
   logic [11:0] csr_addr = '0;
   logic [31:0] csr_wdata = '0;
   logic [31:0] csr_rdata;
   logic        busy;

   always #5 clock = ~clock;

   fp_ctrl #(.FMA_LAT(LAT)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_opcode (req_opcode),
      .req_funct5 (req_funct5),
      .req_rm     (req_rm),
      .exe_start  (exe_start),
      .exe_unit   (exe_unit),
      .exe_rm     (exe_rm),
      .div_done   (div_done),
      .exe_flags  (exe_flags),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_err   (resp_err),
      .resp_flags (resp_flags),
      .csr_we     (csr_we),
      .csr_addr   (csr_addr),
      .csr_wdata  (csr_wdata),
      .csr_rdata  (csr_rdata),
      .busy       (busy)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // An op is either pending (executing, m_age cycles old) or awaiting response pickup.
   int m_pending, m_age, m_lat, m_unit, m_rm;
   int m_resp, m_err, m_flags;
   int m_fflags, m_frm;

   task automatic model_decode(input logic [6:0] opc, input logic [4:0] f5, input logic [2:0] rm,
                               input int frm, output int unit, output int rmr, output int err,
                               output int lat);
      bit conv;
      conv = 1'b0;
      unit = 3;
      if (opc inside {7'h43, 7'h47, 7'h4B, 7'h4F}) unit = 1;
      else if (opc == 7'h53) begin
         if (f5 inside {5'h00, 5'h01, 5'h02}) unit = 1;
         else if (f5 inside {5'h03, 5'h0B}) unit = DIV_EN ? 2 : 3;
         else if (f5 inside {5'h04, 5'h05, 5'h14, 5'h1C, 5'h1E}) unit = 0;
         else if (f5 inside {5'h08, 5'h18, 5'h1A}) begin
            unit = 0;
            conv = 1'b1;
         end
      end
      rmr = (rm == 3'b111) ? frm : int'(rm);
      err = (unit == 3 || ((unit != 0 || conv) && rmr >= 5)) ? 1 : 0;
      lat = (unit == 1) ? LAT : 1;
   endtask

   task automatic model_step();
      int unit, rmr, err, lat, o_frm;
      o_frm = m_frm;
      if (reset) begin
         m_pending = 0; m_age = 0; m_lat = 1; m_unit = 0; m_rm = 0;
         m_resp = 0; m_err = 0; m_flags = 0; m_fflags = 0; m_frm = 0;
         return;
      end
      if (csr_we) begin
         case (csr_addr)
            12'h001: m_fflags = int'(csr_wdata[4:0]);
            12'h002: m_frm = int'(csr_wdata[2:0]);
            12'h003: begin
               m_fflags = int'(csr_wdata[4:0]);
               m_frm    = int'(csr_wdata[7:5]);
            end
            default: ;
         endcase
      end
      if (m_pending != 0) begin
         if ((m_unit == 2) ? (div_done == 1'b1) : (m_age + 1 >= m_lat)) begin
            m_fflags  = m_fflags | int'(exe_flags);
            m_flags   = int'(exe_flags);
            m_err     = 0;
            m_resp    = 1;
            m_pending = 0;
         end else begin
            m_age++;
         end
      end else if (m_resp != 0) begin
         if (resp_ready) m_resp = 0;
      end else if (req_valid) begin
         model_decode(req_opcode, req_funct5, req_rm, o_frm, unit, rmr, err, lat);
         if (err != 0) begin
            m_resp = 1; m_err = 1; m_flags = 0;
         end else begin
            m_pending = 1; m_age = 0; m_unit = unit; m_rm = rmr; m_lat = lat;
         end
      end
   endtask

   function automatic logic [31:0] model_rdata(input logic [11:0] a);
      case (a)
         12'h001: return 32'(m_fflags);
         12'h002: return 32'(m_frm);
         12'h003: return 32'(m_frm * 32 + m_fflags);
         default: return 32'd0;
      endcase
   endfunction

   initial forever begin
      @(posedge clock);
      model_step();
   end

   // Every-cycle comparison against the model, away from the active edge.
   initial forever begin
      @(negedge clock);
      if (cmp_en) begin
         check("req_ready", 32'(req_ready), 32'(m_pending == 0 && m_resp == 0));
         check("busy", 32'(busy), 32'(m_pending != 0 || m_resp != 0));
         check("exe_start", 32'(exe_start), 32'(m_pending != 0 && m_age == 0));
         if (m_pending != 0) begin
            check("exe_unit", 32'(exe_unit), 32'(m_unit));
            check("exe_rm", 32'(exe_rm), 32'(m_rm));
         end
         check("resp_valid", 32'(resp_valid), 32'(m_resp));
         if (m_resp != 0) begin
            check("resp_err", 32'(resp_err), 32'(m_err));
            check("resp_flags", 32'(resp_flags), 32'(m_flags));
         end
         check("csr_rdata", csr_rdata, model_rdata(csr_addr));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
      csr_we = 1'b1; csr_addr = a; csr_wdata = d;
      tick();
      csr_we = 1'b0;
   endtask

   task automatic csr_expect(input string name, input logic [11:0] a, input logic [31:0] exp);
      csr_addr = a;
      #1;
      check(name, csr_rdata, exp);
   endtask

   task automatic issue(input logic [6:0] opc, input logic [4:0] f5, input logic [2:0] rm);
      req_valid = 1'b1; req_opcode = opc; req_funct5 = f5; req_rm = rm;
      for (int k = 0; k < 20 && !req_ready; k++) tick();
      check("accept_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end

   initial begin
      // Reset state
      tick();
      cmp_en = 1'b1;
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_err", 32'(resp_err), 32'd0);
      check("rst_resp_flags", 32'(resp_flags), 32'd0);
      check("rst_exe_start", 32'(exe_start), 32'd0);
      csr_expect("rst_fcsr", 12'h003, 32'd0);
      reset = 1'b0;
      tick();
      check("rst_req_ready", 32'(req_ready), 32'd1);

      // fsgnj: start next cycle, response the cycle after
      issue(7'h53, 5'h04, 3'b000);
      check("sgnj_start", 32'(exe_start), 32'd1);
      check("sgnj_unit", 32'(exe_unit), 32'd0);
      tick();
      check("sgnj_resp_valid", 32'(resp_valid), 32'd1);
      check("sgnj_resp_err", 32'(resp_err), 32'd0);
      tick();
      check("sgnj_back_idle", 32'(req_ready), 32'd1);

      // fmadd with dynamic rm resolved from frm=010
      csr_write(12'h002, 32'h2);
      csr_expect("frm_write", 12'h002, 32'h2);
      exe_flags = 5'b00001;
      issue(7'h43, 5'h00, 3'b111);
      check("fma_start", 32'(exe_start), 32'd1);
      check("fma_rm", 32'(exe_rm), 32'h2);
      check("fma_unit", 32'(exe_unit), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("fma_not_done", 32'(resp_valid), 32'd0);
      end
      tick();
      check("fma_resp_valid", 32'(resp_valid), 32'd1);
      check("fma_resp_flags", 32'(resp_flags), 32'h01);
      csr_expect("fma_fflags", 12'h001, 32'h01);
      tick();

      // fadd with reserved rm: rejected without a start
      exe_flags = 5'b11111;
      issue(7'h53, 5'h00, 3'b101);
      check("bad_rm_start", 32'(exe_start), 32'd0);
      check("bad_rm_valid", 32'(resp_valid), 32'd1);
      check("bad_rm_err", 32'(resp_err), 32'd1);
      check("bad_rm_flags", 32'(resp_flags), 32'd0);
      tick();
      csr_expect("bad_rm_fflags", 12'h001, 32'h01);

      // fdiv with back-pressure on the response
      exe_flags = 5'b00000;
      resp_ready = 1'b0;
      issue(7'h53, 5'h03, 3'b000);
      if (DIV_EN) begin
         check("div_start", 32'(exe_start), 32'd1);
         check("div_unit", 32'(exe_unit), 32'd2);
         for (int i = 0; i < 9; i++) begin
            check("div_wait_ready", 32'(req_ready), 32'd0);
            tick();
         end
         div_done = 1'b1; exe_flags = 5'b01000;
         tick();
         div_done = 1'b0; exe_flags = 5'b00000;
         check("div_resp_err", 32'(resp_err), 32'd0);
      end else begin
         check("div_disabled_start", 32'(exe_start), 32'd0);
         check("div_disabled_err", 32'(resp_err), 32'd1);
      end
      div_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("div_held_valid", 32'(resp_valid), 32'd1);
         check("div_held_ready", 32'(req_ready), 32'd0);
         tick();
      end
      div_done = 1'b0;
      resp_ready = 1'b1;
      tick();
      check("div_released", 32'(req_ready), 32'd1);
      csr_expect("div_fflags", 12'h001, DIV_EN ? 32'h09 : 32'h01);

      // frm write during FMA exec; fcsr write on the completion edge
      exe_flags = 5'b00100;
      issue(7'h43, 5'h00, 3'b000);
      tick();
      csr_write(12'h002, 32'h1);
      check("frm_late_rm", 32'(exe_rm), 32'd0);
      csr_expect("frm_late_val", 12'h002, 32'h1);
      tick();
      csr_write(12'h003, 32'h0);
      check("wr_cmpl_valid", 32'(resp_valid), 32'd1);
      csr_expect("wr_cmpl_fflags", 12'h001, 32'h04);
      csr_expect("wr_cmpl_fcsr", 12'h003, 32'h04);
      exe_flags = 5'b00000;
      tick();

      // reset in the middle of an FMA
      csr_write(12'h003, 32'h65);
      csr_expect("fcsr_65", 12'h003, 32'h65);
      issue(7'h4F, 5'h00, 3'b111);
      tick();
      reset = 1'b1;
      tick();
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_valid", 32'(resp_valid), 32'd0);
      check("midrst_start", 32'(exe_start), 32'd0);
      csr_expect("midrst_fflags", 12'h001, 32'd0);
      csr_expect("midrst_frm", 12'h002, 32'd0);
      reset = 1'b0;
      tick();
      check("midrst_ready", 32'(req_ready), 32'd1);

      // rm legality boundaries with frm=101
      csr_write(12'h002, 32'h5);
      issue(7'h53, 5'h04, 3'b111);
      check("sgnj_frm101_start", 32'(exe_start), 32'd1);
      tick(); tick();
      issue(7'h53, 5'h18, 3'b111);
      check("cvt_frm101_err", 32'(resp_err), 32'd1);
      tick();
      issue(7'h53, 5'h18, 3'b100);
      check("cvt_rm100_start", 32'(exe_start), 32'd1);
      tick(); tick();
      issue(7'h00, 5'h00, 3'b000);
      check("bad_opcode_err", 32'(resp_err), 32'd1);
      tick();
      issue(7'h53, 5'h1F, 3'b000);
      check("bad_funct5_err", 32'(resp_err), 32'd1);
      tick();

      // CSR map edges
      csr_write(12'h004, 32'hFFFF_FFFF);
      csr_expect("unmapped_read", 12'h004, 32'd0);
      csr_expect("unmapped_nowrite", 12'h003, 32'hA0);
      csr_write(12'h003, 32'hFFFF_FFFF);
      csr_expect("fcsr_zext", 12'h003, 32'hFF);
      csr_expect("fflags_zext", 12'h001, 32'h1F);
      csr_expect("frm_zext", 12'h002, 32'h7);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
